plic_source_cell: RTL and testbench
===================================

// Module: plic_source_cell
// PURPOSE
//  Per-source interrupt gateway plus a multi-target source/target cell column.
//  Converts a raw level or edge request into a single pending request.
//  Tracks the claim/complete handshake and presents a registered ID/priority to each of TARGETS targets.
//  Feeds the per-target max-priority trees in the PLIC core.
// PARAMETERS
//  ID                 1                     source number driven on id_o (1..SOURCES; 0 reserved)
//  SOURCES            8                     no. of interrupt sources
//  PRIORITIES         7                     no. of priority levels
//  TARGETS            2                     no. of targets (contexts) served by this cell
//  MAX_PENDING_COUNT  8                     edge-mode saturation limit for queued edges, >=1
//  SOURCES_BITS       $clog2(SOURCES+1)     width of id_o per target
//  PRIORITY_BITS      $clog2(PRIORITIES)    width of priority per target
//  COUNT_BITS         $clog2(MAX_PENDING_COUNT+1)  width of edge counter
// PORTS
//  clk_i       in   1                       system clock; single clock domain
//  rst_ni      in   1                       synchronous active-low reset
//  src_i       in   1                       raw interrupt request, synchronous to clk_i
//  el_i        in   1                       trigger mode: 1=edge (rising), 0=level (high)
//  ie_i        in   TARGETS                 interrupt enable, one bit per target
//  priority_i  in   PRIORITY_BITS           source priority; 0 = never interrupts
//  claim_i     in   1                       1-cycle pulse: some target claimed this ID
//  complete_i  in   1                       1-cycle pulse: some target completed this ID
//  ip_o        out  1                       interrupt pending (readable IP bit)
//  id_o        out  TARGETS*SOURCES_BITS    per-target ID, target t at [t*SOURCES_BITS +: SOURCES_BITS]
//  priority_o  out  TARGETS*PRIORITY_BITS   per-target priority, packed likewise
// BEHAVIOUR
//  Reset: rst_ni low at a clk_i edge sets state=IDLE, cnt=0, src_q=0, ip_o=0, all id_o/priority_o=0.
//   Reset mid-operation discards pending, claimed and queued edges; no replay after reset.
//  Edge detect: edge = src_i & ~src_q; src_q <= src_i every cycle.
//  FSM states and transitions:
//   IDLE->PENDING: level mode when src_i=1; edge mode when (edge | cnt!=0).
//   PENDING->CLAIMED: on claim_i.
//   CLAIMED->IDLE: on complete_i; the gateway re-arms and re-evaluates src_i/cnt the next cycle.
//  Level mode:
//   - src_i deasserting while PENDING does not retract; the request stays pending until claimed.
//   - cnt held at 0.
//  Edge counter (edge mode only):
//   - An edge in any state increments cnt, saturating at MAX_PENDING_COUNT; edges beyond that are lost.
//   - An IDLE->PENDING transition consumes one: cnt_next = cnt + edge - 1 (edge arriving in IDLE with cnt=0 leaves cnt=0).
//  Ignored and simultaneous events:
//   - claim_i outside PENDING and complete_i outside CLAIMED are ignored.
//   - claim_i and complete_i together in PENDING: claim taken, complete ignored.
//  el_i is quasi-static. A change clears cnt on the next cycle; state is unaffected.
//  ip_o = (state==PENDING), registered. Latency: request at cycle n -> ip_o=1 at n+1. claim_i at n -> ip_o=0 at n+1.
//  Per target t (registered, same cycle as ip_o):
//   - If next_state==PENDING & ie_i[t] & priority_i!=0: id_o[t]=ID and priority_o[t]=priority_i.
//   - Otherwise id_o[t]=0 and priority_o[t]=0.
//   - A claimed source therefore drops out of every target's tree.
//  Widths: cnt is unsigned COUNT_BITS; no wrap permitted (saturate both ends). ID must fit SOURCES_BITS.
// STRUCTURE
//  plic_pkg:
//   - typedef enum logic [1:0] {IDLE, PENDING, CLAIMED} plic_gw_state_t;
//   - trigger-mode constants PLIC_LEVEL=1'b0, PLIC_EDGE=1'b1.
//  Sub-module plic_gateway (FSM, src_q, cnt, ip_o, next-state pending flag). The top wraps it with a generate loop
//   of TARGETS output registers.
// TESTING
//  Cfg ID=3, TARGETS=2, PRIORITIES=7, MAX_PENDING_COUNT=4.
//  1. Level, ie=2'b01, prio=5, src_i=1 at cycle 10 -> cycle 11: ip_o=1, id_o[0]=3, prio_o[0]=5, id_o[1]=0.
//     Drop src_i at 12 -> ip_o stays 1.
//  2. Claim at 20 -> cycle 21: ip_o=0, all outputs 0. src_i still 1, complete at 25 -> IDLE at 26, PENDING/ip_o=1 at 27.
//  3. Edge, 6 rising edges while CLAIMED -> cnt=4 (saturated).
//     Then 4 complete/claim rounds each re-pend; 5th complete -> stays IDLE, ip_o=0.
//  4. prio_i=0 with ie=2'b11, src pending -> ip_o=1 but id_o/prio_o all 0.
//     prio_i->6 -> next cycle id_o[0]=id_o[1]=3.
//  5. claim_i and complete_i same cycle in PENDING -> CLAIMED.
//     complete_i in IDLE -> no change. claim_i in CLAIMED -> no change.
//  6. rst_ni low for one cycle while PENDING with cnt=2 -> next cycle all outputs 0, cnt=0; no re-pend without a new edge.

Source files
------------

// File: rtl/plic_pkg.sv
// Shared types and constants for the PLIC source cell and its gateway.
// Holds the gateway state encoding and trigger-mode values.
package plic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        CLAIMED = 2'd2
    } plic_gw_state_t;

    localparam logic PLIC_LEVEL = 1'b0;
    localparam logic PLIC_EDGE  = 1'b1;

endpackage

// File: rtl/plic_gateway.sv
// Interrupt gateway: turns a level or rising-edge request into one pending
// request and tracks the claim/complete handshake, queueing extra edges.
module plic_gateway
    import plic_pkg::*;
#(
    parameter int MAX_PENDING_COUNT = 8,
    parameter int COUNT_BITS        = $clog2(MAX_PENDING_COUNT + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic src_i,
    input  logic el_i,
    input  logic claim_i,
    input  logic complete_i,
    output logic ip_o,
    output logic pend_next_o
);

    localparam logic [COUNT_BITS-1:0] CNT_MAX = COUNT_BITS'(MAX_PENDING_COUNT);
    localparam logic [COUNT_BITS-1:0] CNT_ONE = COUNT_BITS'(1);

    plic_gw_state_t state_q;
    plic_gw_state_t state_d;

    logic                  src_q;
    logic                  el_q;
    logic [COUNT_BITS-1:0] cnt_q;
    logic [COUNT_BITS-1:0] cnt_d;
    logic                  rise;
    logic                  el_chg;
    logic                  req;
    logic                  take;

    assign rise   = src_i & ~src_q;
    assign el_chg = el_i ^ el_q;
    assign req    = (el_i == PLIC_EDGE) ? (rise | (cnt_q != '0)) : src_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req)        state_d = PENDING;
            PENDING: if (claim_i)    state_d = CLAIMED;
            CLAIMED: if (complete_i) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    assign take = (state_q == IDLE) && (state_d == PENDING);

    // A transition out of IDLE consumes one queued edge: cnt + rise - 1.
    always_comb begin
        cnt_d = cnt_q;
        if (el_chg || el_i == PLIC_LEVEL) begin
            cnt_d = '0;
        end else if (take) begin
            if (!rise && cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
        end else if (rise && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= 1'b0;
            el_q    <= el_i;
            ip_o    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_i;
            el_q    <= el_i;
            ip_o    <= (state_d == PENDING);
        end
    end

    assign pend_next_o = (state_d == PENDING);

endmodule

// File: rtl/plic_source_cell.sv
// PLIC source/target cell: one gateway plus a registered ID/priority
// column feeding each target's max-priority tree.
module plic_source_cell
    import plic_pkg::*;
#(
    parameter int ID                = 1,
    parameter int SOURCES           = 8,
    parameter int PRIORITIES        = 7,
    parameter int TARGETS           = 2,
    parameter int MAX_PENDING_COUNT = 8,
    parameter int SOURCES_BITS      = $clog2(SOURCES + 1),
    parameter int PRIORITY_BITS     = $clog2(PRIORITIES),
    parameter int COUNT_BITS        = $clog2(MAX_PENDING_COUNT + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               src_i,
    input  logic                               el_i,
    input  logic [TARGETS-1:0]                 ie_i,
    input  logic [PRIORITY_BITS-1:0]           priority_i,
    input  logic                               claim_i,
    input  logic                               complete_i,
    output logic                               ip_o,
    output logic [TARGETS*SOURCES_BITS-1:0]    id_o,
    output logic [TARGETS*PRIORITY_BITS-1:0]   priority_o
);

    localparam logic [SOURCES_BITS-1:0] ID_VAL = SOURCES_BITS'(ID);

    logic pend_next;
    logic prio_nz;

    plic_gateway #(
        .MAX_PENDING_COUNT (MAX_PENDING_COUNT),
        .COUNT_BITS        (COUNT_BITS)
    ) u_gateway (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .src_i       (src_i),
        .el_i        (el_i),
        .claim_i     (claim_i),
        .complete_i  (complete_i),
        .ip_o        (ip_o),
        .pend_next_o (pend_next)
    );

    assign prio_nz = (priority_i != '0);

    // Registered alongside ip_o so a claimed source leaves every tree at once.
    for (genvar t = 0; t < TARGETS; t++) begin : g_tgt
        logic                     hit;
        logic [SOURCES_BITS-1:0]  id_q;
        logic [PRIORITY_BITS-1:0] prio_q;

        assign hit = pend_next & ie_i[t] & prio_nz;

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                id_q   <= '0;
                prio_q <= '0;
            end else begin
                id_q   <= hit ? ID_VAL : '0;
                prio_q <= hit ? priority_i : '0;
            end
        end

        assign id_o[t*SOURCES_BITS +: SOURCES_BITS]       = id_q;
        assign priority_o[t*PRIORITY_BITS +: PRIORITY_BITS] = prio_q;
    end

endmodule

// File: tb/tb_plic_source_cell.sv
// Self-checking bench for plic_source_cell (ID=3, 2 targets, 4 queued edges).
// Expected outputs are queued per driven cycle and checked after each edge.
module tb_plic_source_cell;

    localparam int ID   = 3;
    localparam int SRCS = 8;
    localparam int PRIS = 7;
    localparam int TGTS = 2;
    localparam int MPC  = 4;
    localparam int SB   = $clog2(SRCS + 1);
    localparam int PB   = $clog2(PRIS);

    logic                clk = 1'b0;
    logic                rst_n;
    logic                src;
    logic                el;
    logic [TGTS-1:0]     ie;
    logic [PB-1:0]       prio;
    logic                claim;
    logic                complete;
    logic                ip;
    logic [TGTS*SB-1:0]  id;
    logic [TGTS*PB-1:0]  po;

    typedef struct {
        string         tag;
        logic          ip;
        logic [SB-1:0] id0;
        logic [SB-1:0] id1;
        logic [PB-1:0] p0;
        logic [PB-1:0] p1;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    plic_source_cell #(
        .ID                (ID),
        .SOURCES           (SRCS),
        .PRIORITIES        (PRIS),
        .TARGETS           (TGTS),
        .MAX_PENDING_COUNT (MPC)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .src_i      (src),
        .el_i       (el),
        .ie_i       (ie),
        .priority_i (prio),
        .claim_i    (claim),
        .complete_i (complete),
        .ip_o       (ip),
        .id_o       (id),
        .priority_o (po)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    always @(posedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            #1;
            e = sb.pop_front();
            check({e.tag, ".ip"},  32'(ip),          32'(e.ip));
            check({e.tag, ".id0"}, 32'(id[0+:SB]),   32'(e.id0));
            check({e.tag, ".id1"}, 32'(id[SB+:SB]),  32'(e.id1));
            check({e.tag, ".pr0"}, 32'(po[0+:PB]),   32'(e.p0));
            check({e.tag, ".pr1"}, 32'(po[PB+:PB]),  32'(e.p1));
        end
    end

    task automatic step(input string tag, input logic e_ip,
                        input logic [SB-1:0] i0, input logic [SB-1:0] i1,
                        input logic [PB-1:0] p0, input logic [PB-1:0] p1);
        exp_t e;
        e.tag = tag;
        e.ip  = e_ip;
        e.id0 = i0;
        e.id1 = i1;
        e.p0  = p0;
        e.p1  = p1;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic z(input string tag);
        step(tag, 1'b0, '0, '0, '0, '0);
    endtask

    // Pending, target 0 enabled, priority 5.
    task automatic pend(input string tag);
        step(tag, 1'b1, SB'(ID), '0, PB'(5), '0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation bound reached");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        src      = 1'b0;
        el       = 1'b0;
        ie       = 2'b01;
        prio     = 3'd5;
        claim    = 1'b0;
        complete = 1'b0;
        z("rst");
        z("rst2");
        rst_n = 1'b1;
        z("idle");

        // level request, held after src drops
        src = 1'b1; pend("lvl_req");
        src = 1'b0; pend("lvl_hold");
        pend("lvl_hold2");

        // claim, complete, re-arm with src still high
        src = 1'b1; claim = 1'b1; z("claim");
        claim = 1'b0; z("claimed");
        complete = 1'b1; z("complete");
        complete = 1'b0; pend("rearm");

        // priority zero masks every target
        ie = 2'b11; prio = 3'd0;
        step("prio0", 1'b1, '0, '0, '0, '0);
        prio = 3'd6;
        step("prio6", 1'b1, SB'(ID), SB'(ID), PB'(6), PB'(6));

        // simultaneous claim/complete, ignored pulses
        claim = 1'b1; complete = 1'b1; z("claim_cmp");
        complete = 1'b0; z("claim_in_claimed");
        claim = 1'b0; complete = 1'b1; src = 1'b0; z("cmp_to_idle");
        z("cmp_in_idle");
        complete = 1'b0; z("idle3");
        ie = 2'b01; prio = 3'd5;

        // edge mode, saturating queue of 4
        el = 1'b1; z("to_edge");
        z("edge_quiet");
        src = 1'b1; pend("e_req");
        claim = 1'b1; z("e_claim");
        claim = 1'b0;
        for (int k = 0; k < 6; k++) begin
            src = 1'b0; z("e_low");
            src = 1'b1; z("e_rise");
        end
        for (int r = 0; r < 4; r++) begin
            claim = 1'b0; complete = 1'b1; z("q_cmp");
            complete = 1'b0; pend("q_repend");
            claim = 1'b1; z("q_claim");
        end
        claim = 1'b0; complete = 1'b1; z("cmp5");
        complete = 1'b0; z("no_repend");
        z("no_repend2");

        // reset mid-operation with two queued edges
        src = 1'b0; z("r_low");
        src = 1'b1; pend("r_edge");
        src = 1'b0; pend("r_q0");
        src = 1'b1; pend("r_q1");
        src = 1'b0; pend("r_q1b");
        src = 1'b1; pend("r_q2");
        src = 1'b0; rst_n = 1'b0; z("rst_mid");
        rst_n = 1'b1; z("post_rst");
        z("post_rst2");
        z("post_rst3");
        src = 1'b1; pend("new_edge");

        repeat (2) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
